// File: rtl/wb_target_router.sv
// wb_target_router
// Registered Wishbone router and bus supervisor between the management-SoC
// slave port of the user wrapper and two user targets. Slave 0 is selected by
// adr[31:24] == S0_BASE, the local status/control register by CSR_BASE, and
// slave 1 takes every other address. The target is latched when a transfer is
// accepted. Each forwarded access has an ack timeout, and faults are counted.
//
// Ports
//   wb_clk_i, wb_rst_n          : clock, asynchronous active-low reset
//   wbs_*_i / wbs_ack_o/dat_o   : master-side Wishbone slave port (registered ack/data)
//   s0_* / s1_*                 : target-side Wishbone master ports (latched request)
//   s0_irq_i, s1_irq_i          : target interrupt vectors
//   user_irq                    : registered IRQs of the IO owner (bit 2 also flags a fault)
//   io_owner                    : 0 = slave 0 owns the IO pads, 1 = slave 1
module wb_target_router #(
  parameter logic [7:0]  S0_BASE    = 8'h38,
  parameter logic [7:0]  CSR_BASE   = 8'h3F,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] FAULT_DATA = 32'hBAD0_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  output logic        s0_we_o,
  output logic [3:0]  s0_sel_o,
  output logic [31:0] s0_adr_o,
  output logic [31:0] s0_dat_o,
  input  logic        s0_ack_i,
  input  logic [31:0] s0_dat_i,
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  output logic        s1_we_o,
  output logic [3:0]  s1_sel_o,
  output logic [31:0] s1_adr_o,
  output logic [31:0] s1_dat_o,
  input  logic        s1_ack_i,
  input  logic [31:0] s1_dat_i,
  input  logic [2:0]  s0_irq_i,
  input  logic [2:0]  s1_irq_i,
  output logic [2:0]  user_irq,
  output logic        io_owner
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_CSR, ST_RESP} state_t;
  state_t state_reg, state_next;

  logic [31:0] adr_reg, dat_reg, rdat_reg;
  logic [3:0]  sel_reg;
  logic        we_reg, tgt_reg, csr_op_reg;
  logic        stb_reg, ack_reg;
  logic [15:0] wait_reg, err_cnt_reg, err_cnt_next;
  logic        err_sticky_reg, err_sticky_next;
  logic        last_tgt_reg, io_owner_reg, io_owner_next;
  logic [2:0]  irq_reg;

  logic        req, slv_ack, fwd_ack, fwd_timeout, fwd_abort;
  logic        csr_wr, csr_clr;
  logic [31:0] slv_dat, csr_image;

  // A request is not taken while our own ack is still out: the master has not
  // yet had a chance to drop the strobe of the transfer just completed.
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign slv_ack = tgt_reg ? s1_ack_i : s0_ack_i;
  assign slv_dat = tgt_reg ? s1_dat_i : s0_dat_i;

  // Acks and wait cycles only count once the strobe is actually presented.
  assign fwd_abort   = (state_reg == ST_FWD) & ~wbs_cyc_i;
  assign fwd_ack     = (state_reg == ST_FWD) & wbs_cyc_i & stb_reg & slv_ack;
  assign fwd_timeout = (state_reg == ST_FWD) & wbs_cyc_i & stb_reg & ~slv_ack &
                       (wait_reg == WAIT_LAST);

  // CSR writes are applied on the edge that raises the master ack.
  assign csr_wr  = (state_reg == ST_RESP) & csr_op_reg & we_reg;
  assign csr_clr = csr_wr & sel_reg[0] & dat_reg[1];

  assign csr_image = {err_cnt_reg, 7'd0, io_owner_reg, 6'd0, err_sticky_reg, last_tgt_reg};

  always_comb begin
    io_owner_next   = io_owner_reg;
    err_sticky_next = err_sticky_reg;
    err_cnt_next    = err_cnt_reg;
    if (csr_wr && sel_reg[1]) io_owner_next = dat_reg[8];
    if (csr_clr) begin
      err_sticky_next = 1'b0;
      err_cnt_next    = 16'd0;
    end else if (fwd_timeout) begin
      err_sticky_next = 1'b1;
      if (err_cnt_reg != 16'hFFFF) err_cnt_next = err_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req) state_next = (wbs_adr_i[31:24] == CSR_BASE) ? ST_CSR : ST_FWD;
      ST_FWD: begin
        if (fwd_abort)                   state_next = ST_IDLE;
        else if (fwd_ack || fwd_timeout) state_next = ST_RESP;
      end
      ST_CSR:  state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      adr_reg        <= '0;
      dat_reg        <= '0;
      sel_reg        <= '0;
      we_reg         <= 1'b0;
      tgt_reg        <= 1'b0;
      csr_op_reg     <= 1'b0;
      stb_reg        <= 1'b0;
      ack_reg        <= 1'b0;
      rdat_reg       <= '0;
      wait_reg       <= '0;
      err_cnt_reg    <= '0;
      err_sticky_reg <= 1'b0;
      last_tgt_reg   <= 1'b0;
      io_owner_reg   <= 1'b0;
      irq_reg        <= '0;
    end else begin
      if (state_reg == ST_IDLE && req) begin
        adr_reg    <= wbs_adr_i;
        dat_reg    <= wbs_dat_i;
        sel_reg    <= wbs_sel_i;
        we_reg     <= wbs_we_i;
        tgt_reg    <= (wbs_adr_i[31:24] != S0_BASE);
        csr_op_reg <= (wbs_adr_i[31:24] == CSR_BASE);
        wait_reg   <= '0;
      end else if (state_reg == ST_FWD && stb_reg) begin
        wait_reg <= wait_reg + 16'd1;
      end

      // Strobe lags the state by one edge; abort and timeout drop it at once.
      stb_reg <= (state_reg == ST_FWD) & wbs_cyc_i & ~fwd_timeout;
      ack_reg <= (state_reg == ST_RESP);

      if (fwd_ack)
        rdat_reg <= we_reg ? 32'd0 : slv_dat;
      else if (fwd_timeout)
        rdat_reg <= FAULT_DATA | {31'd0, tgt_reg};
      else if (state_reg == ST_CSR)
        rdat_reg <= we_reg ? 32'd0 : csr_image;

      if (state_reg == ST_RESP && !csr_op_reg) last_tgt_reg <= tgt_reg;

      err_cnt_reg    <= err_cnt_next;
      err_sticky_reg <= err_sticky_next;
      io_owner_reg   <= io_owner_next;
      // Uses the next-state owner/sticky so the IRQ source flips on the same
      // edge as a CSR write takes effect.
      irq_reg <= (io_owner_next ? s1_irq_i : s0_irq_i) | {err_sticky_next, 2'b00};
    end
  end

  logic s0_act, s1_act;
  assign s0_act = stb_reg & ~tgt_reg;
  assign s1_act = stb_reg & tgt_reg;

  assign s0_cyc_o = s0_act;
  assign s0_stb_o = s0_act;
  assign s0_we_o  = s0_act & we_reg;
  assign s0_sel_o = s0_act ? sel_reg : 4'd0;
  assign s0_adr_o = s0_act ? adr_reg : 32'd0;
  assign s0_dat_o = s0_act ? dat_reg : 32'd0;

  assign s1_cyc_o = s1_act;
  assign s1_stb_o = s1_act;
  assign s1_we_o  = s1_act & we_reg;
  assign s1_sel_o = s1_act ? sel_reg : 4'd0;
  assign s1_adr_o = s1_act ? adr_reg : 32'd0;
  assign s1_dat_o = s1_act ? dat_reg : 32'd0;

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdat_reg;
  assign user_irq  = irq_reg;
  assign io_owner  = io_owner_reg;

endmodule
